// File: rtl/n64_joybus_pkg.sv
// Shared joybus definitions: FSM states, quarter-phase indices, console command opcodes.
package n64_joybus_pkg;

  typedef enum logic [1:0] {IDLE, BIT, STOP} state_t;

  localparam logic [1:0] Q_LOW     = 2'd0;
  localparam logic [1:0] Q_DATA_LO = 2'd1;
  localparam logic [1:0] Q_DATA_HI = 2'd2;
  localparam logic [1:0] Q_HIGH    = 2'd3;
  localparam int         STOP_QUARTERS = 3;

  localparam logic [7:0] CMD_INFO  = 8'h00;
  localparam logic [7:0] CMD_POLL  = 8'h01;
  localparam logic [7:0] CMD_READ  = 8'h02;
  localparam logic [7:0] CMD_WRITE = 8'h03;
  localparam logic [7:0] CMD_RESET = 8'hFF;

  localparam int LEN_INFO  = 1;
  localparam int LEN_POLL  = 1;
  localparam int LEN_READ  = 3;
  localparam int LEN_WRITE = 35;
  localparam int LEN_RESET = 1;

  // Frame length the console sends for a given opcode; unknown opcodes send one byte.
  function automatic int cmd_len(input logic [7:0] op);
    case (op)
      CMD_INFO:  return LEN_INFO;
      CMD_POLL:  return LEN_POLL;
      CMD_READ:  return LEN_READ;
      CMD_WRITE: return LEN_WRITE;
      CMD_RESET: return LEN_RESET;
      default:   return 1;
    endcase
  endfunction

endpackage

// File: rtl/n64_bit_timer.sv
// Quarter-bit timer: counts Q cycles per quarter and steps a 2-bit phase on each wrap.
// Runs while run is high; clear restarts at phase 0, count 0.
module n64_bit_timer
  import n64_joybus_pkg::*;
#(
  parameter int CLKS_PER_US = 50
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       clear,
  input  logic       run,
  output logic [1:0] phase,
  output logic       quarter_end,
  output logic       bit_end
);

  localparam int CNT_W = (CLKS_PER_US > 1) ? $clog2(CLKS_PER_US) : 1;

  logic [CNT_W-1:0] cnt;

  assign quarter_end = run & (cnt == CNT_W'(CLKS_PER_US - 1));
  assign bit_end     = quarter_end & (phase == Q_HIGH);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt   <= '0;
      phase <= Q_LOW;
    end else if (clear) begin
      cnt   <= '0;
      phase <= Q_LOW;
    end else if (run) begin
      if (quarter_end) begin
        cnt   <= '0;
        phase <= phase + 2'd1;
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end

endmodule

// File: rtl/n64_joybus_tx.sv
// Joybus command transmitter: streams 1..MAX_BYTES bytes MSB first plus console stop bit.
// One byte of prefetch keeps bytes gap-free; an empty prefetch at the byte deadline ends the frame with underrun.
module n64_joybus_tx
  import n64_joybus_pkg::*;
#(
  parameter int CLKS_PER_US = 50,
  parameter int MAX_BYTES   = 35,
  parameter int LEN_W       = $clog2(MAX_BYTES + 1)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [LEN_W-1:0] len,
  input  logic [7:0]       tx_data,
  input  logic             tx_valid,
  output logic             tx_ready,
  output logic             data_out,
  output logic             busy,
  output logic             done,
  output logic             underrun
);

  state_t           state;
  logic [7:0]       shreg;
  logic [2:0]       bidx;
  logic [7:0]       nxt;
  logic             nxt_full;
  logic [LEN_W-1:0] remaining;
  logic             short_frame;

  logic [1:0]       phase;
  logic             quarter_end;
  logic             bit_end;
  logic             accept;
  logic             deadline;
  logic [LEN_W-1:0] len_c;

  assign len_c    = (len > LEN_W'(MAX_BYTES)) ? LEN_W'(MAX_BYTES) : len;
  assign accept   = tx_valid & tx_ready;
  assign deadline = (state == BIT) & bit_end & (bidx == 3'd0);

  always_comb begin
    tx_ready = 1'b0;
    if (!rst) begin
      case (state)
        IDLE:    tx_ready = start & (len != '0);
        BIT:     tx_ready = ~nxt_full & (remaining != '0);
        default: tx_ready = 1'b0;
      endcase
    end
  end

  n64_bit_timer #(.CLKS_PER_US(CLKS_PER_US)) u_timer (
    .clk         (clk),
    .rst         (rst),
    .clear       (state == IDLE && accept),
    .run         (state != IDLE),
    .phase       (phase),
    .quarter_end (quarter_end),
    .bit_end     (bit_end)
  );

  // data_out is set one cycle ahead from the phase that is about to begin.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      data_out    <= 1'b1;
      busy        <= 1'b0;
      done        <= 1'b0;
      underrun    <= 1'b0;
      shreg       <= '0;
      bidx        <= '0;
      nxt         <= '0;
      nxt_full    <= 1'b0;
      remaining   <= '0;
      short_frame <= 1'b0;
    end else begin
      done     <= 1'b0;
      underrun <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            shreg       <= tx_data;
            bidx        <= 3'd7;
            remaining   <= len_c - 1'b1;
            nxt_full    <= 1'b0;
            short_frame <= 1'b0;
            data_out    <= 1'b0;
            busy        <= 1'b1;
            state       <= BIT;
          end
        end
        BIT: begin
          if (accept && !deadline) begin
            nxt       <= tx_data;
            nxt_full  <= 1'b1;
            remaining <= remaining - 1'b1;
          end
          if (quarter_end) begin
            case (phase)
              Q_LOW, Q_DATA_LO: data_out <= shreg[7];
              Q_DATA_HI:        data_out <= 1'b1;
              default: begin
                data_out <= 1'b0;
                if (bidx != 3'd0) begin
                  shreg <= {shreg[6:0], 1'b0};
                  bidx  <= bidx - 3'd1;
                end else if (nxt_full) begin
                  shreg    <= nxt;
                  nxt_full <= 1'b0;
                  bidx     <= 3'd7;
                end else if (accept) begin
                  // A byte arriving on the deadline cycle still counts as present.
                  shreg     <= tx_data;
                  remaining <= remaining - 1'b1;
                  bidx      <= 3'd7;
                end else begin
                  short_frame <= (remaining != '0);
                  state       <= STOP;
                end
              end
            endcase
          end
        end
        STOP: begin
          if (quarter_end) begin
            if (phase == Q_LOW) begin
              data_out <= 1'b1;
            end else if (phase == 2'(STOP_QUARTERS - 1)) begin
              data_out <= 1'b1;
              busy     <= 1'b0;
              done     <= 1'b1;
              underrun <= short_frame;
              state    <= IDLE;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_n64_joybus_tx.sv
// Scoreboarded bench for n64_joybus_tx with Q=4 cycles (16-cycle bits).
module tb_n64_joybus_tx;

  localparam int MAXB = 35;
  localparam int LW   = $clog2(MAXB + 1);

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start = 1'b0;
  logic [LW-1:0] len = '0;
  logic [7:0]    tx_data = '0;
  logic          tx_valid = 1'b0;
  logic          tx_ready, data_out, busy, done, underrun;

  n64_joybus_tx #(.CLKS_PER_US(4), .MAX_BYTES(MAXB), .LEN_W(LW)) dut (
    .clk(clk), .rst(rst), .start(start), .len(len), .tx_data(tx_data),
    .tx_valid(tx_valid), .tx_ready(tx_ready), .data_out(data_out),
    .busy(busy), .done(done), .underrun(underrun)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          cycles;
    int          ur;
    int          hs;
    int unsigned sig;
  } exp_t;

  exp_t       sb[$];
  int         tests = 0;
  int         fails = 0;
  logic [7:0] bytes [0:39];

  task automatic chk(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  function automatic int unsigned fold(input int unsigned s, input logic lvl, input int n);
    return s * 33 + (lvl ? 1000 : 0) + n;
  endfunction

  // Expected line waveform as run lengths: 0 bit = 12 low/4 high, 1 bit = 4 low/12 high, stop = 4 low/8 high.
  function automatic int unsigned line_sig(input int n);
    int unsigned s = 0;
    for (int i = 0; i < n; i++) begin
      for (int b = 7; b >= 0; b--) begin
        if (bytes[i][b]) begin s = fold(s, 1'b0, 4);  s = fold(s, 1'b1, 12); end
        else             begin s = fold(s, 1'b0, 12); s = fold(s, 1'b1, 4);  end
      end
    end
    s = fold(s, 1'b0, 4);
    s = fold(s, 1'b1, 8);
    return s;
  endfunction

  task automatic expect_frame(input int cycles, input int ur, input int hs, input int nsent);
    exp_t e;
    e.cycles = cycles; e.ur = ur; e.hs = hs; e.sig = line_sig(nsent);
    sb.push_back(e);
  endtask

  // Monitor: measures each frame on the line and checks it against the scoreboard at done.
  int          m_cycles = 0, m_hs = 0, m_run = 0;
  int unsigned m_sig = 0;
  logic        m_lvl = 1'b1;
  exp_t        m_e;

  always @(negedge clk) begin
    if (rst) begin
      m_cycles = 0; m_hs = 0; m_run = 0; m_sig = 0;
    end else begin
      if (tx_valid && tx_ready) m_hs++;
      if (busy) begin
        m_cycles++;
        if (m_run > 0 && data_out == m_lvl) m_run++;
        else begin
          if (m_run > 0) m_sig = fold(m_sig, m_lvl, m_run);
          m_lvl = data_out;
          m_run = 1;
        end
      end
      if (done) begin
        if (m_run > 0) m_sig = fold(m_sig, m_lvl, m_run);
        if (sb.size() == 0) begin
          chk("unexpected_done", 1, 0);
        end else begin
          m_e = sb.pop_front();
          chk("busy_cycles", m_cycles, m_e.cycles);
          chk("underrun", underrun, m_e.ur);
          chk("handshakes", m_hs, m_e.hs);
          chk("line_waveform_sig", m_sig, m_e.sig);
          chk("busy_low_at_done", busy, 0);
        end
        m_cycles = 0; m_hs = 0; m_run = 0; m_sig = 0;
      end
    end
  end

  task automatic wait_cycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Offer one byte until accepted or budget expires; called and returns #1 after a rising edge.
  task automatic offer(input logic [7:0] b, input int budget, output int ok);
    tx_data = b; tx_valid = 1'b1; ok = 0;
    for (int c = 0; c < budget && ok == 0; c++) begin
      @(negedge clk);
      if (tx_ready) ok = 1;
      @(posedge clk); #1;
    end
    tx_valid = 1'b0;
    start = 1'b0;
  endtask

  task automatic begin_frame(input int l, input logic [7:0] b, output int ok);
    start = 1'b1;
    len = LW'(l);
    offer(b, 10, ok);
  endtask

  task automatic wait_drain(input string name, input int budget);
    for (int c = 0; c < budget && sb.size() != 0; c++) @(posedge clk);
    chk(name, sb.size(), 0);
    wait_cycles(3);
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, tests=%0d", tests);
    $fatal(1, "watchdog");
  end

  int ok, acc;

  initial begin
    // Reset values, with a frame request applied to confirm tx_ready stays low.
    start = 1'b1; len = LW'(1); tx_valid = 1'b1; tx_data = 8'h01;
    repeat (3) @(negedge clk);
    chk("rst_data_out", data_out, 1);
    chk("rst_busy", busy, 0);
    chk("rst_done", done, 0);
    chk("rst_underrun", underrun, 0);
    chk("rst_tx_ready", tx_ready, 0);
    @(posedge clk); #1;
    start = 1'b0; tx_valid = 1'b0; rst = 1'b0;
    wait_cycles(2);

    // Single POLL byte.
    bytes[0] = 8'h01;
    expect_frame(140, 0, 1, 1);
    begin_frame(1, bytes[0], ok);
    chk("poll_accept", ok, 1);
    wait_drain("poll_drain", 400);

    // Three bytes with valid held: gap-free.
    bytes[0] = 8'h02; bytes[1] = 8'h80; bytes[2] = 8'h01;
    expect_frame(396, 0, 3, 3);
    start = 1'b1; len = LW'(3);
    acc = 0;
    for (int i = 0; i < 3; i++) begin offer(bytes[i], 200, ok); acc += ok; end
    chk("read_accepts", acc, 3);
    wait_drain("read_drain", 800);

    // Two requested, one supplied: underrun.
    bytes[0] = 8'h01;
    expect_frame(140, 1, 1, 1);
    begin_frame(2, bytes[0], ok);
    wait_drain("short_drain", 400);

    // Second byte one cycle before the deadline (cycle 127).
    bytes[0] = 8'h55; bytes[1] = 8'hA3;
    expect_frame(268, 0, 2, 2);
    begin_frame(2, bytes[0], ok);
    wait_cycles(126);
    offer(bytes[1], 1, ok);
    chk("early_second_accept", ok, 1);
    wait_drain("early_drain", 600);

    // Second byte exactly on the deadline (cycle 128).
    bytes[0] = 8'hC6; bytes[1] = 8'h3F;
    expect_frame(268, 0, 2, 2);
    begin_frame(2, bytes[0], ok);
    wait_cycles(127);
    offer(bytes[1], 1, ok);
    chk("deadline_second_accept", ok, 1);
    wait_drain("deadline_drain", 600);

    // Second byte one cycle late: underrun, byte never consumed even after the frame ends.
    bytes[0] = 8'h9E;
    expect_frame(140, 1, 1, 1);
    begin_frame(2, bytes[0], ok);
    wait_cycles(128);
    offer(8'h77, 30, ok);
    chk("late_second_refused", ok, 0);
    wait_drain("late_drain", 400);

    // len=0: nothing happens.
    start = 1'b1; len = '0;
    offer(8'hAA, 6, ok);
    chk("len0_refused", ok, 0);
    @(negedge clk);
    chk("len0_busy", busy, 0);
    chk("len0_line", data_out, 1);

    // start/len/tx_valid while busy are ignored.
    bytes[0] = 8'h96;
    expect_frame(140, 0, 1, 1);
    begin_frame(1, bytes[0], ok);
    start = 1'b1; len = LW'(3); tx_valid = 1'b1; tx_data = 8'hAA;
    wait_cycles(50);
    @(negedge clk);
    chk("busy_ignores_tx_ready", tx_ready, 0);
    @(posedge clk); #1;
    start = 1'b0; tx_valid = 1'b0;
    wait_drain("busy_start_drain", 400);

    // len=40 clamps to 35; a 36th byte is refused.
    for (int i = 0; i < 35; i++) bytes[i] = 8'(i * 37 + 5);
    expect_frame(4492, 0, 35, 35);
    start = 1'b1; len = LW'(40);
    acc = 0;
    for (int i = 0; i < 35; i++) begin offer(bytes[i], 200, ok); acc += ok; end
    chk("clamp_accepts", acc, 35);
    offer(8'hEE, 200, ok);
    chk("clamp_extra_refused", ok, 0);
    wait_drain("clamp_drain", 6000);

    // Reset mid-bit releases the line at once; next frame is normal.
    bytes[0] = 8'h00;
    begin_frame(1, bytes[0], ok);
    @(negedge clk);
    chk("pre_rst_line_low", data_out, 0);
    rst = 1'b1;
    #1;
    chk("midrst_data_out", data_out, 1);
    chk("midrst_busy", busy, 0);
    @(posedge clk); #1;
    rst = 1'b0;
    wait_cycles(2);
    bytes[0] = 8'h81;
    expect_frame(140, 0, 1, 1);
    begin_frame(1, bytes[0], ok);
    chk("post_rst_accept", ok, 1);
    wait_drain("post_rst_drain", 400);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/n64_joybus_tx.md
# n64_joybus_tx

Parametrised N64 joybus command transmitter: serialises a host-to-controller command frame of 1..MAX_BYTES bytes onto the single-wire joybus line, MSB first, followed by the console stop bit. Bytes stream in over a valid/ready handshake with one byte of prefetch, so long commands are sent gap-free; a missing byte at its deadline ends the frame early and flags underrun. It sits between the controller-poll sequencer and the open-drain line driver, with the receiver on the same line.

## Interface
- CLKS_PER_US, default 50: clk cycles per 1 µs quarter-bit (Q); must be ≥2.
- MAX_BYTES, default 35: longest frame (write-memory command is 35 bytes).
- LEN_W, default $clog2(MAX_BYTES+1): width of len.

- clk  in  1  system clock.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  frame request; sampled only in IDLE.
- len  in  LEN_W  byte count, sampled with start; 0 means no frame; values >MAX_BYTES are clamped to MAX_BYTES.
- tx_data  in  8  byte to send.
- tx_valid  in  1  tx_data valid.
- tx_ready  out  1  byte accepted when tx_valid & tx_ready.
- data_out  out  1  line level; 1 = released/high, 0 = driven low.
- busy  out  1  frame in progress.
- done  out  1  one-cycle pulse at frame end.
- underrun  out  1  one-cycle pulse coincident with done when the frame was cut short.

## Operation
- States: IDLE, BIT, STOP.
- IDLE: tx_ready = start & (len≠0), combinational. Frame begins only on start & len≠0 & tx_valid; that byte loads the shift register, bit index becomes 7, remaining count becomes len−1, and the state moves to BIT. Otherwise start is ignored, and no done pulse is produced.
- Each bit is four quarters of Q cycles. q0: 0. q1–q2: the bit value. q3: 1. So a 0 bit is 3 µs low + 1 µs high, and a 1 bit is 1 µs low + 3 µs high.
- Prefetch register nxt with a full flag. In BIT, tx_ready = ~nxt_full & (fetched < len). Fetches are allowed at any time during the current byte.
- Deadline is the last cycle of q3 of bit 0 of the current byte.
  - If nxt_full at the deadline: nxt moves to the shift register and the next bit starts the following cycle with no gap.
  - If bytes remain but nxt is empty: underrun. Go to STOP; no further fetches.
  - If no bytes remain: go to STOP.
- STOP: q0 = 0, then q1–q2 = 1 (3 quarters). On the last stop cycle, return to IDLE.
- done pulses for one cycle on the first IDLE cycle after STOP, with underrun pulsing alongside if applicable. busy falls in that same cycle.
- start, len, tx_valid are ignored while busy.
- Bytes still offered after the frame ends are not consumed.

## Timing
- Reset values: data_out=1, busy=0, done=0, underrun=0, tx_ready=0, state=IDLE. All outputs take these values asynchronously when rst asserts, including mid-frame: the line releases immediately.
- data_out and busy are registered. If start is accepted in cycle 0, data_out=0 and busy=1 from cycle 1.
- Full frame: busy high for len·32·Q + 3·Q cycles.
- Underrun after k bytes: busy high for k·32·Q + 3·Q cycles.
- Quarter counter counts 0..Q−1. Phase and bit index advance on wrap.
- A byte accepted in the same cycle as the deadline counts as present.

## Structure
- Shared package n64_joybus_pkg holds:
  - state enum {IDLE, BIT, STOP};
  - quarter-phase constants (Q_LOW=0, Q_DATA_LO=1, Q_DATA_HI=2, Q_HIGH=3, STOP_QUARTERS=3);
  - command opcodes (INFO=0x00, POLL=0x01, READ=0x02, WRITE=0x03, RESET=0xFF) and their frame lengths (1, 1, 3, 35, 1).
- One sub-module, n64_bit_timer: Q-cycle quarter counter with 2-bit phase index and a last-quarter strobe, cleared on frame start. It is shared later with the receiver.

## Test plan
CLKS_PER_US=4 (Q=4, bit=16 cycles) for all scenarios.
- start, len=1, 0x01 with tx_valid: seven bits of 12 low / 4 high, one bit of 4 low / 12 high, then stop 4 low / 8 high. busy=1 for 140 cycles; one done pulse; underrun=0.
- len=3, bytes 0x02, 0x80, 0x01 with tx_valid held: no gap between bytes; busy=1 for 396 cycles; exactly 3 handshakes.
- len=2, only 0x01 supplied: stop bit follows byte 1 directly; busy=1 for 140 cycles; done and underrun pulse together.
- len=2, second byte offered 1 cycle before the first byte's deadline, and separately exactly on the deadline: both gap-free, 268 busy cycles. Offered 1 cycle late: underrun.
- Ignore cases:
  - start with len=0: no line activity, tx_ready=0, no done.
  - start during busy: frame unaffected.
  - len=40: clamped to 35, and 35 bytes are fetched.
- rst asserted mid-bit while data_out=0: data_out=1 and busy=0 within the same cycle. A new start after deassertion sends a correct frame.
